preset_sequencer: RTL and testbench
===================================

PRESET_SEQUENCER -- requirements
Module: preset_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width of the cell under test.
REQ-002 SHALL have parameter NUM_PRESETS, default 8, number of test vectors; must be a power of two, max 8.
REQ-003 SHALL have parameter CELL_LATENCY, default 2, cycles from param_load/operands valid to cell result valid; range 1..15.
REQ-004 SHALL have port clk, input, 1, single clock.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port start, input, 1, one-cycle pulse from debouncer; runs the current preset.
REQ-007 SHALL have port next_preset, input, 1, one-cycle pulse; advances the preset index.
REQ-008 SHALL have port cell_out, input, 2*DATA_WIDTH, result from the cell.
REQ-009 SHALL have port code, output, 3, current preset index.
REQ-010 SHALL have port param_load, output, 1, parameter-load strobe to the cell.
REQ-011 SHALL have ports inp, par, output, DATA_WIDTH each, and prop, output, 2*DATA_WIDTH; these are the operands to the cell.
REQ-012 SHALL have ports busy, pass, fail, output, 1 each, and fail_count, output, 4.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, WAIT, CHECK, DONE.
REQ-014 In IDLE, start SHALL move to LOAD on the next cycle; start and next_preset in the same cycle: start wins and next_preset is dropped.
REQ-015 LOAD SHALL last one cycle with param_load=1; par, inp and prop SHALL be driven from the preset and held until the next LOAD or reset.
REQ-016 WAIT SHALL last exactly CELL_LATENCY cycles, counted by a down-counter loaded in LOAD.
REQ-017 CHECK SHALL last one cycle and compare cell_out against the expected result, full 2*DATA_WIDTH width, unsigned.
REQ-018 In the DONE cycle, on a match pass=1 and fail=0; on a mismatch fail=1, pass=0, and fail_count increments, saturating at 15.
REQ-019 The FSM SHALL go from DONE to IDLE after one cycle; pass and fail SHALL stay sticky until the next start or next_preset.
REQ-020 busy SHALL be 1 in LOAD, WAIT and CHECK, else 0.
REQ-021 start or next_preset while busy SHALL be ignored.
REQ-022 next_preset in IDLE or DONE SHALL increment code modulo NUM_PRESETS (7->0 wrap) and clear pass and fail.
REQ-023 param_load SHALL never be asserted outside LOAD.

Reset
REQ-024 Reset SHALL drive the FSM to IDLE asynchronously.
REQ-025 Reset SHALL clear code, param_load, inp, par, prop, busy, pass, fail, fail_count and the WAIT counter to 0.
REQ-026 Reset mid-run SHALL abort the run with no pass/fail update; the first start after release SHALL behave as from power-up.

Configuration
REQ-027 With macro PRESET_SWEEP_EN defined, start SHALL run presets 0..NUM_PRESETS-1 back-to-back (LOAD..CHECK per preset, code tracks the active preset) and end in one DONE.
REQ-028 In a sweep, pass SHALL be 1 only if every preset matched, and fail_count SHALL equal the number of mismatches; code returns to its pre-sweep value at DONE.
REQ-029 Without PRESET_SWEEP_EN, start SHALL run only the current preset and no sweep logic SHALL be present.

Structure
REQ-030 Package sys_array_pkg SHALL hold the preset_t struct (inp, par, prop, result), the PRESET_TABLE constant and the FSM state enum.
REQ-031 A sub-module preset_rom SHALL map code combinationally to a preset_t.
REQ-032 The table values SHALL be: preset 0 = 3,5,10 -> 25; preset 1 = 255,255,0 -> 65025; preset 2 = 0,7,100 -> 100; preset k>2 = k,k,k -> k*k+k.

Verification
REQ-033 Reset; start; model cell = inp*par+prop with 2-cycle latency -> param_load high exactly 1 cycle after start, DONE 5 cycles after start, pass=1, fail_count=0.
REQ-034 Preset 1 with a model returning 65024 -> fail=1, pass=0, fail_count=1; 16 further failing runs -> fail_count saturates at 15.
REQ-035 Issue 8 next_preset pulses -> code steps 1..7 then 0; start and next_preset together in IDLE -> run on the old code, code unchanged.
REQ-036 Pulse start and next_preset during WAIT -> no effect; reset asserted during WAIT -> all outputs 0 immediately, no pass or fail.
REQ-037 With PRESET_SWEEP_EN and a correct model -> 8 param_load pulses, pass=1, fail_count=0; corrupt preset 2 only -> fail=1, fail_count=1.

Source files
------------

// File: rtl/sys_array_pkg.sv
// sys_array_pkg: preset vector type, preset table and sequencer state encoding.
package sys_array_pkg;
  typedef struct packed {
    logic [7:0]  inp;
    logic [7:0]  par;
    logic [15:0] prop;
    logic [15:0] result;
  } preset_t;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, DONE} state_t;
  localparam preset_t PRESET_TABLE [8] = '{
    '{8'd3,   8'd5,   16'd10,  16'd25},
    '{8'd255, 8'd255, 16'd0,   16'd65025},
    '{8'd0,   8'd7,   16'd100, 16'd100},
    '{8'd3,   8'd3,   16'd3,   16'd12},
    '{8'd4,   8'd4,   16'd4,   16'd20},
    '{8'd5,   8'd5,   16'd5,   16'd30},
    '{8'd6,   8'd6,   16'd6,   16'd42},
    '{8'd7,   8'd7,   16'd7,   16'd56}
  };
endpackage

// File: rtl/preset_rom.sv
// preset_rom: combinational lookup of a preset vector by index.
module preset_rom
  import sys_array_pkg::*;
(
  input  logic [2:0] code_i,
  output preset_t    preset_o
);
  assign preset_o = PRESET_TABLE[code_i];
endmodule

// File: rtl/preset_sequencer.sv
// preset_sequencer: drives preset vectors into a cell and checks its result.
// Define PRESET_SWEEP_EN to make start run every preset back-to-back.
module preset_sequencer
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_PRESETS  = 8,
  parameter int CELL_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    next_preset,
  input  logic [2*DATA_WIDTH-1:0] cell_out,
  output logic [2:0]              code,
  output logic                    param_load,
  output logic [DATA_WIDTH-1:0]   inp,
  output logic [DATA_WIDTH-1:0]   par,
  output logic [2*DATA_WIDTH-1:0] prop,
  output logic                    busy,
  output logic                    pass,
  output logic                    fail,
  output logic [3:0]              fail_count
);
  localparam int W2 = 2 * DATA_WIDTH;
  localparam logic [2:0] CMAX = 3'(NUM_PRESETS - 1);
  state_t state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [3:0] cnt_q, fc_q;
  logic [DATA_WIDTH-1:0] inp_q, par_q;
  logic [W2-1:0] prop_q, exp_q;
  logic pass_q, fail_q;
  logic go, nxt, miss, bad, last;
  preset_t rom;
  // ROM follows next-state code so operands land exactly as LOAD begins
  preset_rom u_rom (.code_i(code_d), .preset_o(rom));
  assign go   = state_q == IDLE && start;
  assign nxt  = (state_q == IDLE || state_q == DONE) && next_preset && !go;
  assign miss = cell_out != exp_q;
`ifdef PRESET_SWEEP_EN
  logic [2:0] orig_q;
  logic any_q;
  assign last = code_q == CMAX;
  assign bad  = any_q | miss;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      orig_q <= '0;
      any_q  <= 1'b0;
    end else if (go) begin
      orig_q <= code_q;
      any_q  <= 1'b0;
    end else if (state_q == CHECK) any_q <= bad;
`else
  assign last = 1'b1;
  assign bad  = miss;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    code_d  = nxt ? (code_q + 3'd1) & CMAX : code_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = WAIT;
      WAIT:    state_d = cnt_q == 4'd0 ? CHECK : WAIT;
      CHECK:   state_d = last ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef PRESET_SWEEP_EN
    if (go) code_d = '0;
    else if (state_q == CHECK) code_d = last ? orig_q : code_q + 3'd1;
`endif
  end
  always_comb begin
    param_load = state_q == LOAD;
    busy       = state_q == LOAD || state_q == WAIT || state_q == CHECK;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      code_q <= '0;
      cnt_q  <= '0;
      fc_q   <= '0;
      inp_q  <= '0;
      par_q  <= '0;
      prop_q <= '0;
      exp_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      code_q <= code_d;
      if (state_d == LOAD) begin
        inp_q  <= DATA_WIDTH'(rom.inp);
        par_q  <= DATA_WIDTH'(rom.par);
        prop_q <= W2'(rom.prop);
        exp_q  <= W2'(rom.result);
        cnt_q  <= 4'(CELL_LATENCY - 1);
      end else if (state_q == WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (go || nxt) begin
        pass_q <= 1'b0;
        fail_q <= 1'b0;
      end else if (state_q == CHECK && last) begin
        pass_q <= !bad;
        fail_q <= bad;
      end
      if (state_q == CHECK && miss && fc_q != 4'd15) fc_q <= fc_q + 4'd1;
    end
  assign code       = code_q;
  assign inp        = inp_q;
  assign par        = par_q;
  assign prop       = prop_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign fail_count = fc_q;
endmodule

// File: tb/tb_preset_sequencer.sv
// tb_preset_sequencer: randomized self-checking bench with a pipelined cell model.
module tb_preset_sequencer;
  localparam int DW = 8;
  localparam int NP = 8;
  localparam int CL = 2;
  logic clk = 1'b0;
  logic reset, start, next_preset;
  logic [2*DW-1:0] cell_out;
  logic [2:0] code;
  logic param_load, busy, pass, fail;
  logic [DW-1:0] inp, par;
  logic [2*DW-1:0] prop;
  logic [3:0] fail_count;
  logic [7:0] corrupt = '0;
  logic [15:0] s1 = '0, s2 = '0;
  int tests = 0, fails = 0;
  int m_code = 0, m_fc = 0;
  bit m_pass = 0, m_fail = 0;
  preset_sequencer #(.DATA_WIDTH(DW), .NUM_PRESETS(NP), .CELL_LATENCY(CL)) dut (
    .clk(clk), .reset(reset), .start(start), .next_preset(next_preset),
    .cell_out(cell_out), .code(code), .param_load(param_load), .inp(inp),
    .par(par), .prop(prop), .busy(busy), .pass(pass), .fail(fail),
    .fail_count(fail_count)
  );
  always #5 clk = ~clk;
  // cell under test: inp*par+prop after CL=2 registers, optionally off by one per preset
  always @(posedge clk) begin
    s1 <= 16'(inp) * 16'(par) + prop - 16'(corrupt[code]);
    s2 <= s1;
  end
  assign cell_out = s2;
  function automatic int ref_inp(int k);
    return k == 0 ? 3 : k == 1 ? 255 : k == 2 ? 0 : k;
  endfunction
  function automatic int ref_par(int k);
    return k == 0 ? 5 : k == 1 ? 255 : k == 2 ? 7 : k;
  endfunction
  function automatic int ref_prop(int k);
    return k == 0 ? 10 : k == 1 ? 0 : k == 2 ? 100 : k;
  endfunction
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; next_preset = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({code, param_load, inp, par, prop, busy, pass, fail, fail_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: code=%0d pl=%b inp=%0d par=%0d prop=%0d busy=%b pass=%b fail=%b fc=%0d, required all 0",
               code, param_load, inp, par, prop, busy, pass, fail, fail_count);
    end
    reset = 1'b0;
    @(negedge clk);
    m_code = 0; m_fc = 0; m_pass = 0; m_fail = 0;
  endtask
  task automatic run(input bit both, input bit poke);
    int n_run, mism, loads, cyc, idx;
    bit done;
    @(negedge clk);
    start = 1'b1; next_preset = both;
    @(negedge clk);
    start = 1'b0; next_preset = 1'b0;
`ifdef PRESET_SWEEP_EN
    n_run = NP;
`else
    n_run = 1;
`endif
    mism = 0;
    for (int i = 0; i < n_run; i++) begin
      idx = n_run == 1 ? m_code : i;
      if (corrupt[idx]) mism++;
    end
    loads = 0; cyc = 1; done = 0;
    while (!done && cyc < 200) begin
      if (param_load) begin
        idx = n_run == 1 ? m_code : loads;
        tests++;
        if (loads < n_run && (code !== 3'(idx) || inp !== DW'(ref_inp(idx)) ||
            par !== DW'(ref_par(idx)) || prop !== 16'(ref_prop(idx)))) begin
          fails++;
          $display("FAIL load_operands: code=%0d inp=%0d par=%0d prop=%0d, required code=%0d inp=%0d par=%0d prop=%0d",
                   code, inp, par, prop, idx, ref_inp(idx), ref_par(idx), ref_prop(idx));
        end
        loads++;
      end
      start = poke && cyc == 2; next_preset = poke && cyc == 2;
      if (!busy) done = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; next_preset = 1'b0;
    m_fc = m_fc + mism > 15 ? 15 : m_fc + mism;
    m_pass = mism == 0; m_fail = mism != 0;
    tests++;
    if (!done || cyc != n_run * (2 + CL) + 1 || loads != n_run) begin
      fails++;
      $display("FAIL run_timing: done=%b cycles=%0d loads=%0d, required done=1 cycles=%0d loads=%0d",
               done, cyc, loads, n_run * (2 + CL) + 1, n_run);
    end
    tests++;
    if (pass !== m_pass || fail !== m_fail || fail_count !== 4'(m_fc) || code !== 3'(m_code)) begin
      fails++;
      $display("FAIL run_result: pass=%b fail=%b fc=%0d code=%0d, required pass=%b fail=%b fc=%0d code=%0d",
               pass, fail, fail_count, code, m_pass, m_fail, m_fc, m_code);
    end
  endtask
  task automatic pulse_next();
    @(negedge clk);
    next_preset = 1'b1;
    @(negedge clk);
    next_preset = 1'b0;
    m_code = (m_code + 1) % NP; m_pass = 0; m_fail = 0;
    tests++;
    if (code !== 3'(m_code) || pass !== 1'b0 || fail !== 1'b0) begin
      fails++;
      $display("FAIL next_preset: code=%0d pass=%b fail=%b, required code=%0d pass=0 fail=0", code, pass, fail, m_code);
    end
  endtask
  task automatic test_basic();
    corrupt = '0;
    run(0, 0);
  endtask
  task automatic test_fail_saturate();
    pulse_next();
    corrupt = 8'h02;
    for (int i = 0; i < 17; i++) run(0, 0);
  endtask
  task automatic test_next_preset();
    corrupt = '0;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse_next();
    end
    run(1, 0);
  endtask
  task automatic test_busy_ignore();
    corrupt = '0;
    run(0, 1);
  endtask
  task automatic test_sweep_corrupt();
    test_reset();
    pulse_next();
    pulse_next();
    corrupt = 8'h04;
    run(0, 0);
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({code, param_load, inp, par, prop, busy, pass, fail, fail_count} !== '0) begin
      fails++;
      $display("FAIL reset_mid_run: code=%0d pl=%b busy=%b pass=%b fail=%b fc=%0d, required all 0",
               code, param_load, busy, pass, fail, fail_count);
    end
    @(negedge clk);
    reset = 1'b0;
    m_code = 0; m_fc = 0; m_pass = 0; m_fail = 0;
    corrupt = '0;
    run(0, 0);
  endtask
  task automatic test_random();
    test_reset();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) pulse_next();
      corrupt = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
      run($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_fail_saturate();
    test_next_preset();
    test_busy_ignore();
    test_sweep_corrupt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
